instr_dispatch_fsm: RTL and testbench

Top-level fetch/decode/dispatch controller for the datapath. It fetches one 16-bit instruction per pass through the shared MAR/MDR/memory handshake and decodes the opcode. It then hands the operand selectors `p1`/`p2` to exactly one execution FSM (load, store or ALU) with a one-cycle start pulse, and waits for that FSM's `finish` before fetching the next instruction.

---
 rtl/instr_dispatch_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_instr_dispatch_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch_fsm.sv
// Fetch/decode/dispatch controller: fetches a 16-bit instruction over the MAR/MDR
// handshake, decodes it and hands p1/p2 to one execution FSM. Optional watchdog: DISPATCH_TIMEOUT_EN.
module instr_dispatch_fsm
`ifdef DISPATCH_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        MFC,
    input  logic [15:0] ir,
    input  logic        load_finish,
    input  logic        store_finish,
    input  logic        alu_finish,
    output logic        PCout,
    output logic        MARin,
    output logic        PCinc,
    output logic        memEn,
    output logic        memOp,
    output logic        MDRread,
    output logic        MDRout,
    output logic        IRin,
    output logic        load_start,
    output logic        store_start,
    output logic        alu_start,
    output logic [5:0]  p1,
    output logic [5:0]  p2,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] instr_count
);

    localparam int unsigned ST_W   = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned P_W    = 6;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned ENG_W  = 2;

    localparam logic [ST_W-1:0] S_IDLE = 4'd0;
    localparam logic [ST_W-1:0] S_F1   = 4'd1;
    localparam logic [ST_W-1:0] S_F2   = 4'd2;
    localparam logic [ST_W-1:0] S_F3   = 4'd3;
    localparam logic [ST_W-1:0] S_F4   = 4'd4;
    localparam logic [ST_W-1:0] S_DEC  = 4'd5;
    localparam logic [ST_W-1:0] S_DISP = 4'd6;
    localparam logic [ST_W-1:0] S_WAIT = 4'd7;
    localparam logic [ST_W-1:0] S_HALT = 4'd8;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OP_W-1:0] OP_STORE = 4'h2;
    localparam logic [OP_W-1:0] OP_ALU   = 4'h3;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    localparam logic [ENG_W-1:0] ENG_LOAD  = 2'd0;
    localparam logic [ENG_W-1:0] ENG_STORE = 2'd1;
    localparam logic [ENG_W-1:0] ENG_ALU   = 2'd2;

    // Strobe order: {PCout, MARin, PCinc, memEn, memOp, MDRread, MDRout, IRin}
    localparam logic [CTRL_W-1:0] CTRL_F1 = 8'b1110_0000;
    localparam logic [CTRL_W-1:0] CTRL_F2 = 8'b0001_1000;
    localparam logic [CTRL_W-1:0] CTRL_F3 = 8'b0001_1100;
    localparam logic [CTRL_W-1:0] CTRL_F4 = 8'b0000_0011;

    logic [ST_W-1:0]   state_q, state_d;
    logic [P_W-1:0]    p1_q, p1_d;
    logic [P_W-1:0]    p2_q, p2_d;
    logic [ENG_W-1:0]  eng_q, eng_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [2:0]        start_q, start_d;
    logic              halted_q, halted_d;
    logic              illegal_c;
    logic              sel_finish_c;
    logic [ST_W-1:0]   boundary_c;
    logic [OP_W-1:0]   opcode_c;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned WD_W = 8;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_c;

    // Watchdog restarts at zero on every WAIT entry and counts unfinished WAIT cycles.
    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign opcode_c   = ir[15:12];
    assign boundary_c = run ? S_F1 : S_IDLE;

    always_comb begin
        sel_finish_c = 1'b0;
        case (eng_q)
            ENG_LOAD:  sel_finish_c = load_finish;
            ENG_STORE: sel_finish_c = store_finish;
            ENG_ALU:   sel_finish_c = alu_finish;
            default:   sel_finish_c = 1'b0;
        endcase
    end

    // Next-state, operand latch and retire counter.
    always_comb begin
        state_d       = state_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        eng_d         = eng_q;
        instr_count_d = instr_count_q;
        illegal_c     = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        timeout_c     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_F1;
                end
            end
            S_F1: state_d = S_F2;
            S_F2: begin
                if (MFC) begin
                    state_d = S_F3;
                end
            end
            S_F3: state_d = S_F4;
            S_F4: state_d = S_DEC;
            S_DEC: begin
                p1_d = ir[11:6];
                p2_d = ir[5:0];
                case (opcode_c)
                    OP_LOAD: begin
                        eng_d   = ENG_LOAD;
                        state_d = S_DISP;
                    end
                    OP_STORE: begin
                        eng_d   = ENG_STORE;
                        state_d = S_DISP;
                    end
                    OP_ALU: begin
                        eng_d   = ENG_ALU;
                        state_d = S_DISP;
                    end
                    OP_NOP: begin
                        instr_count_d = instr_count_q + CNT_W'(1);
                        state_d       = boundary_c;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = boundary_c;
                    end
                endcase
            end
            S_DISP: state_d = S_WAIT;
            S_WAIT: begin
                // A finish on the watchdog limit cycle still retires the instruction.
                if (sel_finish_c) begin
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = boundary_c;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC)) begin
                    timeout_c = 1'b1;
                    state_d   = boundary_c;
                end
`endif
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobes registered from the next state so they line up with the state register.
    always_comb begin
        ctrl_d   = '0;
        start_d  = '0;
        halted_d = 1'b0;
        case (state_d)
            S_F1: ctrl_d = CTRL_F1;
            S_F2: ctrl_d = CTRL_F2;
            S_F3: ctrl_d = CTRL_F3;
            S_F4: ctrl_d = CTRL_F4;
            S_DISP: begin
                case (eng_d)
                    ENG_LOAD:  start_d = 3'b100;
                    ENG_STORE: start_d = 3'b010;
                    ENG_ALU:   start_d = 3'b001;
                    default:   start_d = 3'b000;
                endcase
            end
            S_HALT: halted_d = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            p1_q          <= '0;
            p2_q          <= '0;
            eng_q         <= ENG_LOAD;
            instr_count_q <= '0;
            ctrl_q        <= '0;
            start_q       <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            eng_q         <= eng_d;
            instr_count_q <= instr_count_d;
            ctrl_q        <= ctrl_d;
            start_q       <= start_d;
            halted_q      <= halted_d;
        end
    end

    assign {PCout, MARin, PCinc, memEn, memOp, MDRread, MDRout, IRin} = ctrl_q;
    assign {load_start, store_start, alu_start} = start_q;
    assign p1          = p1_q;
    assign p2          = p2_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;
    // The illegal flag marks the DEC cycle itself, so it follows the IR contents directly.
    assign illegal     = illegal_c;
`ifdef DISPATCH_TIMEOUT_EN
    assign timeout     = timeout_c;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed bench for instr_dispatch_fsm: a per-cycle vector table for a LOAD and a NOP,
// then hand sequences for reset, MFC stall, illegal opcode, ALU, watchdog and HALT.
module tb_instr_dispatch_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        MFC;
    logic [15:0] ir;
    logic        load_finish, store_finish, alu_finish;
    logic        PCout, MARin, PCinc, memEn, memOp, MDRread, MDRout, IRin;
    logic        load_start, store_start, alu_start;
    logic [5:0]  p1, p2;
    logic        halted, illegal, timeout;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    instr_dispatch_fsm dut (
        .clk(clk), .reset(reset), .run(run), .MFC(MFC), .ir(ir),
        .load_finish(load_finish), .store_finish(store_finish), .alu_finish(alu_finish),
        .PCout(PCout), .MARin(MARin), .PCinc(PCinc), .memEn(memEn), .memOp(memOp),
        .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin),
        .load_start(load_start), .store_start(store_start), .alu_start(alu_start),
        .p1(p1), .p2(p2), .halted(halted), .illegal(illegal), .timeout(timeout),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_F1   = 8'hE0;
    localparam logic [7:0] C_F2   = 8'h18;
    localparam logic [7:0] C_F3   = 8'h1C;
    localparam logic [7:0] C_F4   = 8'h03;

    typedef struct {
        logic        run;
        logic        mfc;
        logic [15:0] ir;
        logic [2:0]  fin;     // {load, store, alu}
        logic [7:0]  ctrl;
        logic [2:0]  starts;  // {load, store, alu}
        logic        ill;
        logic [5:0]  p1;
        logic [5:0]  p2;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [7:0] ctrl_now();
        return {PCout, MARin, PCinc, memEn, memOp, MDRread, MDRout, IRin};
    endfunction

    function automatic logic [2:0] starts_now();
        return {load_start, store_start, alu_start};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [15:0] i, input logic [2:0] f,
                                input logic [7:0] c, input logic [2:0] s, input logic il,
                                input logic [5:0] a, input logic [5:0] b, input logic [15:0] n);
        vec_t v;
        v.run = r; v.mfc = 1'b1; v.ir = i; v.fin = f; v.ctrl = c; v.starts = s;
        v.ill = il; v.p1 = a; v.p2 = b; v.cnt = n;
        return v;
    endfunction

    initial begin
        // LOAD 0x1042 with finish six cycles after the start pulse, then a NOP with run dropped.
        tbl[0]  = mk(1, 16'h1042, 3'b000, C_F1,   3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 16'h1042, 3'b000, C_F2,   3'b000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 16'h1042, 3'b000, C_F3,   3'b000, 0, 0, 0, 0);
        tbl[3]  = mk(1, 16'h1042, 3'b000, C_F4,   3'b000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 16'h1042, 3'b000, C_NONE, 3'b000, 0, 0, 0, 0);
        tbl[5]  = mk(1, 16'h1042, 3'b000, C_NONE, 3'b100, 0, 1, 2, 0);
        tbl[6]  = mk(1, 16'h1042, 3'b000, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[7]  = mk(1, 16'h1042, 3'b000, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[8]  = mk(1, 16'h1042, 3'b010, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[9]  = mk(1, 16'h1042, 3'b001, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[10] = mk(1, 16'h1042, 3'b000, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[11] = mk(1, 16'h1042, 3'b000, C_NONE, 3'b000, 0, 1, 2, 0);
        tbl[12] = mk(1, 16'h1042, 3'b100, C_F1,   3'b000, 0, 1, 2, 1);
        tbl[13] = mk(0, 16'h0000, 3'b000, C_F2,   3'b000, 0, 1, 2, 1);
        tbl[14] = mk(0, 16'h0000, 3'b000, C_F3,   3'b000, 0, 1, 2, 1);
        tbl[15] = mk(0, 16'h0000, 3'b000, C_F4,   3'b000, 0, 1, 2, 1);
        tbl[16] = mk(0, 16'h0000, 3'b000, C_NONE, 3'b000, 0, 1, 2, 1);
        tbl[17] = mk(0, 16'h0000, 3'b000, C_NONE, 3'b000, 0, 0, 0, 2);
        tbl[18] = mk(0, 16'h0000, 3'b000, C_NONE, 3'b000, 0, 0, 0, 2);

        reset = 1'b0; run = 1'b0; MFC = 1'b0; ir = 16'h0000;
        load_finish = 1'b0; store_finish = 1'b0; alu_finish = 1'b0;
        step();
        step();
        reset = 1'b1;

        // Reset asserted while stalled in F2, run held high.
        run = 1'b1;
        step();
        step();
        chk("f2_reached", 32'(memEn & memOp), 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_reset_ctrl", 32'(ctrl_now()), 32'd0);
        step();
        chk("reset_ctrl", 32'(ctrl_now()), 32'd0);
        chk("reset_starts", 32'(starts_now()), 32'd0);
        chk("reset_flags", 32'({halted, illegal, timeout}), 32'd0);
        chk("reset_p", 32'({p1, p2}), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run = tbl[i].run; MFC = tbl[i].mfc; ir = tbl[i].ir;
            {load_finish, store_finish, alu_finish} = tbl[i].fin;
            step();
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ctrl));
            chk($sformatf("vec%0d_start", i), 32'(starts_now()), 32'(tbl[i].starts));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
            chk($sformatf("vec%0d_p1", i), 32'(p1), 32'(tbl[i].p1));
            chk($sformatf("vec%0d_p2", i), 32'(p2), 32'(tbl[i].p2));
            chk($sformatf("vec%0d_count", i), 32'(instr_count), 32'(tbl[i].cnt));
        end
        {load_finish, store_finish, alu_finish} = 3'b000;

        // ALU dispatch; a load_finish in WAIT must be ignored.
        run = 1'b1; MFC = 1'b1; ir = 16'h3FC1;
        for (int i = 0; i < 5; i++) step();
        chk("alu_dec", 32'(ctrl_now()), 32'd0);
        step();
        chk("alu_start", 32'(starts_now()), 32'b001);
        chk("alu_p1", 32'(p1), 32'h3F);
        chk("alu_p2", 32'(p2), 32'h01);
        step();
        load_finish = 1'b1;
        step();
        load_finish = 1'b0;
        chk("alu_ignore_load_fin", 32'(ctrl_now()), 32'd0);
        chk("alu_ignore_count", 32'(instr_count), 32'd2);
        alu_finish = 1'b1;
        step();
        alu_finish = 1'b0;
        chk("alu_retire_f1", 32'(ctrl_now()), 32'(C_F1));
        chk("alu_retire_count", 32'(instr_count), 32'd3);

        // MFC low for three F2 cycles, then the illegal opcode 0x7000.
        MFC = 1'b0; ir = 16'h7000;
        step();
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("stall_f2_%0d", i), 32'(ctrl_now()), 32'(C_F2));
            step();
        end
        chk("stall_f2_4", 32'(ctrl_now()), 32'(C_F2));
        MFC = 1'b1;
        step();
        chk("stall_f3", 32'(ctrl_now()), 32'(C_F3));
        step();
        step();
        chk("illegal_pulse", 32'(illegal), 32'd1);
        step();
        chk("illegal_no_start", 32'(starts_now()), 32'd0);
        chk("illegal_clear", 32'(illegal), 32'd0);
        chk("illegal_refetch", 32'(ctrl_now()), 32'(C_F1));
        chk("illegal_count", 32'(instr_count), 32'd3);

        // STORE 0x2000 with no store_finish.
        ir = 16'h2000;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("store_start", 32'(starts_now()), 32'b010);
`ifdef DISPATCH_TIMEOUT_EN
        begin
            int k = 0;
            for (int i = 1; i <= 400; i++) begin
                step();
                if (timeout) begin
                    k = i;
                    break;
                end
            end
            chk("timeout_wait_cycle", 32'(k), 32'd256);
            step();
            chk("timeout_clear", 32'(timeout), 32'd0);
            chk("timeout_refetch", 32'(ctrl_now()), 32'(C_F1));
            chk("timeout_count", 32'(instr_count), 32'd3);
        end
`else
        for (int i = 0; i < 300; i++) step();
        chk("wait_hold_ctrl", 32'(ctrl_now()), 32'd0);
        chk("wait_hold_starts", 32'(starts_now()), 32'd0);
        chk("wait_no_timeout", 32'(timeout), 32'd0);
        chk("wait_hold_count", 32'(instr_count), 32'd3);
        chk("wait_hold_p", 32'({p1, p2}), 32'd0);
        #2 reset = 1'b0;
        step();
        chk("wait_reset_count", 32'(instr_count), 32'd0);
        reset = 1'b1;
        step();
        chk("wait_reset_refetch", 32'(ctrl_now()), 32'(C_F1));
`endif

        // HALT: sticky regardless of run, cleared only by reset.
        ir = 16'hF000;
        for (int i = 0; i < 5; i++) step();
        chk("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            step();
            chk($sformatf("halt_hold_%0d", i), 32'({halted, ctrl_now()}), 32'h100);
        end
        #2 reset = 1'b0;
        #1 chk("halt_reset", 32'(halted), 32'd0);
        reset = 1'b1;
        chk("halt_reset_count", 32'(instr_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
